// File: rtl/g_shifter_pipe.sv
// g_shifter_pipe: LOG2W-stage pipelined barrel shifter with valid/ready handshake; define G_SHIFTER_ROTATE_EN to make Op=11 rotate-left (otherwise SLL)
module g_shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [1:0]       Op,
  input  logic             Enable,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             OutValid,
  input  logic             OutReady
);
  logic             adv;
  logic             vld [LOG2W];
  logic [WIDTH-1:0] dat [LOG2W];
  logic [WIDTH-1:0] nxt [LOG2W];
  logic [LOG2W-1:0] amt [LOG2W];
  logic [1:0]       ops [LOG2W];
  logic             ens [LOG2W];
  logic             unused_in2;
  logic             unused_tail;
  assign adv         = ~OutValid | OutReady;
  assign InReady     = adv;
  assign OutValid    = vld[LOG2W-1];
  assign Out         = dat[LOG2W-1];
  assign unused_in2  = ^In2[WIDTH-1:LOG2W];
  assign unused_tail = ^{amt[LOG2W-1], ops[LOG2W-1], ens[LOG2W-1]};
  for (genvar i = 0; i < LOG2W; i++) begin : g_stage
    localparam int S = 1 << i;
    logic             src_vld;
    logic             src_en;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] sll;
    logic [WIDTH-1:0] srl;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] rol;
    logic [LOG2W-1:0] src_amt;
    logic [1:0]       src_op;
    logic             unused_amt;
    if (i == 0) begin : g_head
      assign src_vld = InValid;
      assign src     = In1;
      assign src_amt = In2[LOG2W-1:0];
      assign src_op  = Op;
      assign src_en  = Enable;
    end else begin : g_body
      assign src_vld = vld[i-1];
      assign src     = dat[i-1];
      assign src_amt = amt[i-1];
      assign src_op  = ops[i-1];
      assign src_en  = ens[i-1];
    end
    assign unused_amt = ^src_amt;
    assign sll = src << S;
    assign srl = src >> S;
    assign sra = $signed(src) >>> S;
`ifdef G_SHIFTER_ROTATE_EN
    assign rol = sll | (src >> (WIDTH - S));
`else
    assign rol = sll;
`endif
    assign nxt[i] = (i == LOG2W - 1 && !src_en) ? '0 :
                    !src_amt[i]      ? src :
                    src_op == 2'b00  ? sll :
                    src_op == 2'b01  ? srl :
                    src_op == 2'b10  ? sra : rol;
    // stage register: moves on every global advance, reset drops in-flight work
    always_ff @(posedge Clk)
      if (Rst) begin
        vld[i] <= 1'b0;
        dat[i] <= '0;
      end else if (adv) begin
        vld[i] <= src_vld;
        dat[i] <= nxt[i];
        amt[i] <= src_amt;
        ops[i] <= src_op;
        ens[i] <= src_en;
      end
  end
  // zero flag registered alongside the final stage data
  always_ff @(posedge Clk)
    if (Rst) Zero <= 1'b0;
    else if (adv) Zero <= nxt[LOG2W-1] == '0;
endmodule

// File: tb/tb_g_shifter_pipe.sv
// tb_g_shifter_pipe: randomized and directed self-checking bench for g_shifter_pipe
module tb_g_shifter_pipe;
  localparam int W   = 32;
  localparam int LAT = $clog2(W);
  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] In1;
  logic [W-1:0] In2;
  logic [1:0]   Op;
  logic         Enable;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] Out;
  logic         Zero;
  logic         OutValid;
  logic         OutReady;
  int           n_cmp;
  int           n_bad;

  g_shifter_pipe #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .In1(In1), .In2(In2), .Op(Op), .Enable(Enable),
    .InValid(InValid), .InReady(InReady), .Out(Out), .Zero(Zero),
    .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] ref_shift(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op, logic en);
    int           s;
    logic [W-1:0] ones;
    logic [W-1:0] r;
    s    = int'(b % W);
    ones = '1;
    if (!en) return '0;
    case (op)
      2'b00:   r = a << s;
      2'b01:   r = a >> s;
      2'b10:   r = (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
`ifdef G_SHIFTER_ROTATE_EN
      default: r = (s == 0) ? a : ((a << s) | (a >> (W - s)));
`else
      default: r = a << s;
`endif
    endcase
    return r;
  endfunction

  task automatic idle();
    InValid  = 1'b0;
    OutReady = 1'b1;
    Enable   = 1'b1;
    In1      = '0;
    In2      = '0;
    Op       = 2'b00;
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input logic en,
                        output int lat, output logic [W-1:0] res, output logic z, output logic gone);
    In1 = a; In2 = b; Op = op; Enable = en; InValid = 1'b1; OutReady = 1'b1;
    step();
    InValid = 1'b0;
    In1 = W'({$urandom(), $urandom()});
    In2 = W'($urandom());
    Op  = 2'($urandom());
    lat = 1;
    while (OutValid !== 1'b1 && lat < 4 * LAT) begin
      step();
      lat++;
    end
    res = Out;
    z   = Zero;
    step();
    gone = (OutValid === 1'b0);
  endtask

  task automatic test_reset();
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL rst_outvalid: got %b expected 0", OutValid); end
    n_cmp++; if (Out !== '0)        begin n_bad++; $display("FAIL rst_out: got %h expected 0", Out); end
    n_cmp++; if (Zero !== 1'b0)     begin n_bad++; $display("FAIL rst_zero: got %b expected 0", Zero); end
    n_cmp++; if (InReady !== 1'b1)  begin n_bad++; $display("FAIL rst_inready: got %b expected 1", InReady); end
    Rst = 1'b0;
    OutReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      InValid = 1'b1;
      In1 = W'({$urandom(), $urandom()}) | W'(1);
      In2 = '0;
      step();
    end
    idle();
    OutReady = 1'b0;
    Rst = 1'b1;
    step();
    step();
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL midrst_outvalid: got %b expected 0", OutValid); end
    n_cmp++; if (Out !== '0)        begin n_bad++; $display("FAIL midrst_out: got %h expected 0", Out); end
    n_cmp++; if (Zero !== 1'b0)     begin n_bad++; $display("FAIL midrst_zero: got %b expected 0", Zero); end
    n_cmp++; if (InReady !== 1'b1)  begin n_bad++; $display("FAIL midrst_inready: got %b expected 1", InReady); end
    Rst = 1'b0;
    OutReady = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      step();
      n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL stale_result: cycle %0d got OutValid=%b expected 0", c, OutValid); end
    end
  endtask

  task automatic test_sll();
    int           lat;
    logic [W-1:0] r;
    logic         z;
    logic         g;
    logic [W-1:0] exp;
    exp = {1'b1, {(W-1){1'b0}}};
    launch(W'(1), W'(W - 1), 2'b00, 1'b1, lat, r, z, g);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL sll_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (r !== exp)   begin n_bad++; $display("FAIL sll_max: got %h expected %h", r, exp); end
    n_cmp++; if (z !== 1'b0)  begin n_bad++; $display("FAIL sll_max_zero: got %b expected 0", z); end
    exp = W'(1) << 5;
    launch(W'(1), W'((1 << LAT) | 5), 2'b00, 1'b1, lat, r, z, g);
    n_cmp++; if (r !== exp)   begin n_bad++; $display("FAIL sll_upper_ignored: got %h expected %h", r, exp); end
    launch(W'(32'h1234_5678), W'(W), 2'b00, 1'b1, lat, r, z, g);
    n_cmp++; if (r !== W'(32'h1234_5678)) begin n_bad++; $display("FAIL sll_amount0: got %h expected %h", r, W'(32'h1234_5678)); end
  endtask

  task automatic test_sra();
    int           lat;
    logic [W-1:0] r;
    logic         z;
    logic         g;
    logic [W-1:0] ones;
    logic [W-1:0] msb;
    logic [W-1:0] exp;
    ones = '1;
    msb  = {1'b1, {(W-1){1'b0}}};
    exp  = ~(ones >> 5);
    launch(msb, W'(4), 2'b10, 1'b1, lat, r, z, g);
    n_cmp++; if (r !== exp) begin n_bad++; $display("FAIL sra_neg: got %h expected %h", r, exp); end
    exp = W'(1) << (W - 5);
    launch(msb, W'(4), 2'b01, 1'b1, lat, r, z, g);
    n_cmp++; if (r !== exp) begin n_bad++; $display("FAIL srl_msb: got %h expected %h", r, exp); end
    launch(ones >> 1, W'(W - 1), 2'b10, 1'b1, lat, r, z, g);
    n_cmp++; if (r !== '0)   begin n_bad++; $display("FAIL sra_pos_max: got %h expected 0", r); end
    n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL sra_pos_zero: got %b expected 1", z); end
  endtask

  task automatic test_enable();
    int           lat;
    logic [W-1:0] r;
    logic         z;
    logic         g;
    logic [W-1:0] ones;
    ones = '1;
    launch(ones, W'(1), 2'b00, 1'b0, lat, r, z, g);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL en0_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (r !== '0)    begin n_bad++; $display("FAIL en0_out: got %h expected 0", r); end
    n_cmp++; if (z !== 1'b1)  begin n_bad++; $display("FAIL en0_zero: got %b expected 1", z); end
    n_cmp++; if (g !== 1'b1)  begin n_bad++; $display("FAIL en0_handshake: got drained=%b expected 1", g); end
  endtask

  task automatic test_rotate();
    int           lat;
    logic [W-1:0] r;
    logic         z;
    logic         g;
    logic [W-1:0] a;
    logic [W-1:0] exp;
    a = {1'b1, {(W-2){1'b0}}, 1'b1};
`ifdef G_SHIFTER_ROTATE_EN
    exp = W'(3);
`else
    exp = W'(2);
`endif
    launch(a, W'(1), 2'b11, 1'b1, lat, r, z, g);
    n_cmp++; if (r !== exp) begin n_bad++; $display("FAIL op11: got %h expected %h", r, exp); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q[$];
    logic [W-1:0] e;
    logic [W-1:0] po;
    logic         pz;
    logic         pv;
    logic         pr;
    logic         inx;
    logic         outx;
    int           sent;
    int           got;
    sent = 0; got = 0; pv = 1'b0; pr = 1'b1; po = '0; pz = 1'b0;
    for (int c = 0; c < 400 && got < 16; c++) begin
      if (pv && !pr) begin
        n_cmp++;
        if (OutValid !== 1'b1 || Out !== po || Zero !== pz) begin
          n_bad++;
          $display("FAIL b2b_stall_stable: cycle %0d got v=%b out=%h z=%b expected v=1 out=%h z=%b", c, OutValid, Out, Zero, po, pz);
        end
      end
      OutReady = (c % 3 == 0);
      if (sent < 16 && !InValid) begin
        In1 = W'({$urandom(), $urandom()});
        In2 = W'($urandom());
        Op = 2'($urandom());
        Enable = ($urandom_range(0, 3) != 0);
        InValid = 1'b1;
      end
      #1;
      n_cmp++;
      if (InReady !== !(OutValid && !OutReady)) begin
        n_bad++;
        $display("FAIL b2b_inready: cycle %0d got %b expected %b", c, InReady, !(OutValid && !OutReady));
      end
      inx  = InValid && InReady;
      outx = OutValid && OutReady;
      if (outx) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra: cycle %0d got unexpected result %h expected none", c, Out);
        end else begin
          e = q.pop_front();
          if (Out !== e || Zero !== (e == '0)) begin
            n_bad++;
            $display("FAIL b2b_result%0d: got %h z=%b expected %h z=%b", got, Out, Zero, e, (e == '0));
          end
        end
        got++;
      end
      if (inx) begin
        q.push_back(ref_shift(In1, In2, Op, Enable));
        sent++;
      end
      pv = OutValid; pr = OutReady; po = Out; pz = Zero;
      step();
      if (inx) InValid = 1'b0;
    end
    n_cmp++; if (got !== 16)     begin n_bad++; $display("FAIL b2b_count: got %0d results expected 16", got); end
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL b2b_leftover: got %0d pending expected 0", q.size()); end
    idle();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    Rst = 1'b1;
    step();
    step();
    test_reset();
    test_sll();
    test_sra();
    test_enable();
    test_rotate();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
